// File: rtl/task2_11_pkg.sv
// Shared types and defaults for the task2_11 XOR/sequence-detector block.
package task2_11_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S00  = 2'd1,
    S01  = 2'd2,
    S10  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/task2_11_seq_fsm.sv
// Detects the input pair sequence 00,01,10,11 (repeats allowed) and emits a
// registered one-cycle seq_done pulse after the edge that samples the final 11.
module task2_11_seq_fsm
  import task2_11_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic x,
  input  logic y,
  output logic seq_done
);

  seq_state_e state_q;
  logic       done_q;
  logic [1:0] pair;

  assign pair = {x, y};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // 00 restarts the sequence from any state; it is the only way out of IDLE
      if (pair == 2'b00) begin
        state_q <= S00;
      end else begin
        case (state_q)
          S00:     state_q <= (pair == 2'b01) ? S01 : IDLE;
          S01: begin
            if (pair == 2'b10)      state_q <= S10;
            else if (pair == 2'b11) state_q <= IDLE;
          end
          S10: begin
            if (pair != 2'b10) state_q <= IDLE;
            if (pair == 2'b11) done_q  <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign seq_done = done_q;

endmodule

// File: rtl/task2_11.sv
// Registered XOR of x/y, 00-01-10-11 sequence detector, and optional saturating
// mismatch counter enabled by macro TASK2_11_MISMATCH_CNT_EN (tied to 0 otherwise).
module task2_11
  import task2_11_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             y,
  output logic             z,
  output logic             seq_done,
  output logic [CNT_W-1:0] mismatch_cnt
);

  logic z_q;

  always_ff @(posedge clk) begin
    if (rst) z_q <= 1'b0;
    else     z_q <= x ^ y;
  end

  assign z = z_q;

  task2_11_seq_fsm u_seq_fsm (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .y        (y),
    .seq_done (seq_done)
  );

`ifdef TASK2_11_MISMATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturate at all-ones rather than wrapping
  always_comb begin
    cnt_d = cnt_q;
    if ((x ^ y) && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign mismatch_cnt = cnt_q;
`else
  assign mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_task2_11.sv
// Directed bench for task2_11; counter expectations follow TASK2_11_MISMATCH_CNT_EN.
module tb_task2_11;

`ifdef TASK2_11_MISMATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x   = 1'b0;
  logic       y   = 1'b0;
  logic       z, seq_done;
  logic [7:0] mismatch_cnt;
  logic       z2, seq_done2;
  logic [1:0] mismatch_cnt2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task2_11 #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .z(z), .seq_done(seq_done), .mismatch_cnt(mismatch_cnt)
  );

  task2_11 #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .z(z2), .seq_done(seq_done2), .mismatch_cnt(mismatch_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ec(input int v);
    return CNT_ON ? v : 0;
  endfunction

  // Apply one pair, let the edge sample it, then settle before checking
  task automatic step(input logic [1:0] p, input logic r = 1'b0);
    rst = r;
    {x, y} = p;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic do_reset();
    step(2'b00, 1'b1);
  endtask

  initial begin
    int pulses;

    // Reset state
    do_reset();
    check("rst_z", z, 0);
    check("rst_done", seq_done, 0);
    check("rst_cnt", mismatch_cnt, 0);
    check("rst_cnt_w2", mismatch_cnt2, 0);

    // Basic sequence 00,01,10,11
    step(2'b00); check("s1_z00", z, 0); check("s1_d00", seq_done, 0);
    step(2'b01); check("s1_z01", z, 1); check("s1_d01", seq_done, 0);
    step(2'b10); check("s1_z10", z, 1); check("s1_d10", seq_done, 0);
    step(2'b11); check("s1_z11", z, 0); check("s1_d11", seq_done, 1);
    check("s1_cnt", mismatch_cnt, ec(2));
    // Held 11 must not pulse again
    step(2'b11); check("s1_hold11", seq_done, 0);
    step(2'b11); check("s1_hold11b", seq_done, 0);
    check("s1_cnt_hold", mismatch_cnt, ec(2));

    // Repeated pairs: exactly one pulse, after the first 11
    do_reset();
    pulses = 0;
    step(2'b00); pulses += int'(seq_done);
    step(2'b00); pulses += int'(seq_done);
    step(2'b01); pulses += int'(seq_done);
    step(2'b01); pulses += int'(seq_done);
    step(2'b10); pulses += int'(seq_done);
    step(2'b10); pulses += int'(seq_done);
    step(2'b11); check("s2_done_first11", seq_done, 1); pulses += int'(seq_done);
    step(2'b11); pulses += int'(seq_done);
    check("s2_pulses", pulses, 1);
    check("s2_cnt", mismatch_cnt, ec(4));

    // 11 from S01 aborts the sequence
    do_reset();
    pulses = 0;
    step(2'b00); pulses += int'(seq_done);
    step(2'b01); pulses += int'(seq_done);
    step(2'b11); pulses += int'(seq_done);
    step(2'b10); pulses += int'(seq_done);
    step(2'b11); pulses += int'(seq_done);
    check("s3_pulses", pulses, 0);
    check("s3_cnt", mismatch_cnt, ec(2));

    // 01 from S10 aborts
    do_reset();
    step(2'b00); step(2'b01); step(2'b10); step(2'b01);
    step(2'b11); check("s3b_s10_01_abort", seq_done, 0);

    // Saturation on the 2-bit instance
    do_reset();
    step(2'b10); check("sat_1", mismatch_cnt2, ec(1));
    step(2'b10); check("sat_2", mismatch_cnt2, ec(2));
    step(2'b10); check("sat_3", mismatch_cnt2, ec(3));
    step(2'b10); check("sat_4", mismatch_cnt2, ec(3));
    step(2'b10); check("sat_5", mismatch_cnt2, ec(3));
    step(2'b10); check("sat_6", mismatch_cnt2, ec(3));
    check("sat_w8", mismatch_cnt, ec(6));
    // Reset wins while saturated and mismatching
    step(2'b10, 1'b1);
    check("sat_rst_w2", mismatch_cnt2, 0);
    check("sat_rst_z", z, 0);

    // Reset on the edge that samples 11 in S10
    do_reset();
    step(2'b00); step(2'b01); step(2'b10);
    step(2'b11, 1'b1);
    check("s4_done", seq_done, 0);
    check("s4_z", z, 0);
    check("s4_cnt", mismatch_cnt, 0);
    // First sample after reset is processed normally
    step(2'b01);
    check("s4_post_z", z, 1);
    check("s4_post_cnt", mismatch_cnt, ec(1));
    check("s4_post_done", seq_done, 0);
    // Reset must also have cleared the FSM: 10,11 without 00 gives no pulse
    step(2'b10); step(2'b11);
    check("s4_fsm_cleared", seq_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
